// File: rtl/adder_acc_pipe.sv
// adder_acc_pipe: pipelined add/sub/accumulate/clear unit with a valid/ready
// handshake. A beat is computed when it is accepted, and the accumulator is
// updated on that same edge. The result then travels down a PIPE_STAGES-deep
// register chain. When the output is stalled, the whole chain freezes.
//
// Optional build macro: ADDER_ACC_SAT_EN.
//   Defined   : saturating arithmetic (overflow -> all-ones, borrow -> 0).
//   Undefined : wrap-around arithmetic.
module adder_acc_pipe #(
  parameter int WIDTH       = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] c,
  output logic                 ovf
);

  // One spare bit above the result width. It carries the add/accumulate
  // carry-out and the sign of the subtraction.
  localparam int EW = OUT_WIDTH + 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;
  logic advance;

  // A result the consumer has not taken freezes the whole pipe. Bubbles
  // inside the pipe are deliberately not collapsed.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // First-stage arithmetic
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] acc_d;

  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic [EW-1:0] acc_ext;
  logic [EW-1:0] add_sum;
  logic [EW-1:0] sub_diff;
  logic [EW-1:0] acc_sum;
  logic          borrow;

  assign a_ext   = {{(EW-WIDTH){1'b0}}, a};
  assign b_ext   = {{(EW-WIDTH){1'b0}}, b};
  assign acc_ext = {1'b0, acc_q};

  assign add_sum  = a_ext + b_ext;
  assign sub_diff = a_ext - b_ext;
  assign acc_sum  = acc_ext + a_ext + b_ext;

  // Both operands are far below 2^(EW-1). The top bit of the EW-bit
  // difference is therefore exactly the "b > a" borrow.
  assign borrow = sub_diff[EW-1];

  logic [OUT_WIDTH-1:0] res_d;
  logic                 ovf_d;
  logic [OUT_WIDTH-1:0] beat_acc;

  // Per-mode result, flag and the accumulator value this beat would leave.
  always_comb begin
    res_d    = '0;
    ovf_d    = 1'b0;
    beat_acc = acc_q;
    case (mode)
      MODE_ADD: begin
        res_d = add_sum[OUT_WIDTH-1:0];
        ovf_d = add_sum[OUT_WIDTH];
`ifdef ADDER_ACC_SAT_EN
        if (add_sum[OUT_WIDTH]) res_d = '1;
`endif
      end
      MODE_SUB: begin
        res_d = sub_diff[OUT_WIDTH-1:0];
        ovf_d = borrow;
`ifdef ADDER_ACC_SAT_EN
        if (borrow) res_d = '0;
`endif
      end
      MODE_ACC: begin
        res_d = acc_sum[OUT_WIDTH-1:0];
        ovf_d = acc_sum[OUT_WIDTH];
`ifdef ADDER_ACC_SAT_EN
        if (acc_sum[OUT_WIDTH]) res_d = '1;
`endif
        // The stored accumulator equals the value that was emitted,
        // whether that value wrapped or clamped.
        beat_acc = res_d;
      end
      MODE_CLR: begin
        res_d    = '0;
        ovf_d    = 1'b0;
        beat_acc = '0;
      end
      default: ;
    endcase
  end

  // The accumulator only moves on an accepted beat. Back-to-back accumulates
  // therefore see each other's result with no forwarding needed.
  assign acc_d = accept ? beat_acc : acc_q;

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // ---------------------------------------------------------------------------
  // Result pipeline: stage 0 is loaded on the accept edge, and the last
  // stage drives the outputs.
  // ---------------------------------------------------------------------------
  logic [PIPE_STAGES-1:0]                vld_q;
  logic [PIPE_STAGES-1:0][OUT_WIDTH-1:0] res_q;
  logic [PIPE_STAGES-1:0]                ovf_q;

  // Shift the valid bits and payload one stage per unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      res_q <= '0;
      ovf_q <= '0;
    end else if (advance) begin
      vld_q[0] <= accept;
      // Payload of a bubble is left alone. This keeps c quiet when idle.
      if (accept) begin
        res_q[0] <= res_d;
        ovf_q[0] <= ovf_d;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[PIPE_STAGES-1];
  assign c         = res_q[PIPE_STAGES-1];
  assign ovf       = ovf_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Scoreboard bench for adder_acc_pipe (defaults WIDTH=4, OUT_WIDTH=8,
// PIPE_STAGES=2). Expected results are hand-computed constants. They are
// queued on acceptance and popped by an independent output monitor.
module tb_adder_acc_pipe;

`ifdef ADDER_ACC_SAT_EN
  localparam logic [7:0] SUB_BORROW_C = 8'h00;
  localparam logic [7:0] ACC9_C       = 8'hFF;
`else
  localparam logic [7:0] SUB_BORROW_C = 8'hFE;
  localparam logic [7:0] ACC9_C       = 8'h0E;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] c;
  logic       ovf;

  typedef struct packed {
    logic [7:0] c;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] held_c;

  adder_acc_pipe #(.WIDTH(4), .OUT_WIDTH(8), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every released beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got c=%0h with empty scoreboard at %0t", c, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("result_c", {24'h0, c}, {24'h0, mon_e.c});
        chk("result_ovf", {31'h0, ovf}, {31'h0, mon_e.ovf});
      end
    end
  end

  // Present one beat. The task holds it until accepted, then returns at
  // posedge+1 of the accept edge.
  task automatic send(input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] tm,
                      input logic [7:0] ec, input logic eo);
    bit done = 0;
    a = ta; b = tb_; mode = tm; in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back({ec, eo});
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  // Wait, bounded, until every queued beat has been seen. Then check idle.
  task automatic drain(input string name);
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    chk(name, sbq.size(), 0);
    @(negedge clk);
    chk({name, "_idle_valid"}, {31'h0, out_valid}, 0);
    @(posedge clk); #1;
  endtask

  logic [3:0] bp_a [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9,  4'd11};
  logic [3:0] bp_b [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12};
  logic [7:0] bp_e [6] = '{8'd3, 8'd7, 8'd11, 8'd15, 8'd19, 8'd23};
  logic [7:0] acc_e [9] = '{8'd30, 8'd60, 8'd90, 8'd120, 8'd150, 8'd180, 8'd210, 8'd240, 8'd0};

  initial begin
    // Reset and idle.
    #2;
    chk("rst_c", {24'h0, c}, 0);
    chk("rst_ovf", {31'h0, ovf}, 0);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 1);
    chk("post_rst_out_valid", {31'h0, out_valid}, 0);

    // Single add and its latency.
    send(4'd15, 4'd15, 2'b00, 8'h1E, 1'b0);
    @(negedge clk);
    chk("add_lat_early", {31'h0, out_valid}, 0);
    @(negedge clk);
    chk("add_lat_on", {31'h0, out_valid}, 1);
    @(negedge clk);
    chk("add_lat_one_cycle", {31'h0, out_valid}, 0);
    @(posedge clk); #1;

    // Subtract.
    send(4'd3, 4'd5, 2'b01, SUB_BORROW_C, 1'b1);
    send(4'd9, 4'd4, 2'b01, 8'h05, 1'b0);
    drain("sub_drain");

    // Accumulate chain, then clear, then restart.
    for (int i = 0; i < 8; i++) send(4'd15, 4'd15, 2'b10, acc_e[i], 1'b0);
    send(4'd15, 4'd15, 2'b10, ACC9_C, 1'b1);
    send(4'd7, 4'd7, 2'b11, 8'h00, 1'b0);
    send(4'd1, 4'd1, 2'b10, 8'h02, 1'b0);
    drain("acc_drain");

    // Backpressure: the consumer stalls for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_a[i], bp_b[i], 2'b00, bp_e[i], 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held_c = c;
        chk("stall_in_ready", {31'h0, in_ready}, 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", {31'h0, in_ready}, 0);
          chk("stall_out_valid", {31'h0, out_valid}, 1);
          chk("stall_c_held", {24'h0, c}, {24'h0, held_c});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with beats in flight and acc=60.
    send(4'd5, 4'd5, 2'b11, 8'h00, 1'b0);
    send(4'd15, 4'd15, 2'b10, 8'd30, 1'b0);
    send(4'd15, 4'd15, 2'b10, 8'd60, 1'b0);
    drain("pre_rst_drain");
    out_ready = 1'b0;
    send(4'd1, 4'd1, 2'b00, 8'd2, 1'b0);
    send(4'd2, 4'd2, 2'b00, 8'd4, 1'b0);
    chk("inflight_valid", {31'h0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 0);
    chk("midrst_c", {24'h0, c}, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(4'd1, 4'd2, 2'b10, 8'd3, 1'b0);
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
